keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives a 4x4 matrix keypad: one column active-low at a time, reads the 4 rows (active-low).
- Produces a held key-pressed level and a 4-bit key code.
- key_pressed feeds the KeyP input of the keypad bounce-elimination stage; key_code is the data that stage qualifies.
- This block is the producer side of the key-press/Data_Available interface.

Parameters:
- SCAN_DIV, 27000: clk cycles per scan tick (1 ms at 27 MHz); minimum legal value 4.
- RELEASE_TICKS, 3: consecutive all-rows-high ticks required to declare release; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- row_n  input  4  keypad rows, active-low, asynchronous to clk
- col_n  output  4  keypad column drive, exactly one bit low at any time
- key_pressed  output  1  high while a key is registered and held
- key_code  output  4  row*4 + col of the registered key; held until the next registration
- key_valid  output  1  one-cycle pulse on registration

Behaviour:
- Reset values (rst high at a clk edge), all taking effect on the next cycle:
  - col_idx=0, col_n=4'b1110
  - key_pressed=0, key_code=0, key_valid=0
  - divider=0, release counter=0, state=SCAN
  - sync flops set to 4'b1111
- rst mid-press discards the key; no key_valid is emitted on reset exit.
- row_n passes through a 2-flop synchronizer (row_s), giving 2 clk of latency.
- Divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted for one cycle when divider==SCAN_DIV-1.
  - The divider free-runs in every state.
- col_n = ~(4'b0001 << col_idx), registered.
- Rows are evaluated only on tick. Because the column has been driven for a full tick period, row settling plus sync latency are covered.
- State SCAN, on tick:
  - If any row_s bit is 0: the winner is the lowest-index low row r.
  - key_code <= {r[1:0], col_idx[1:0]}, key_pressed <= 1, key_valid <= 1 for that cycle.
  - col_idx holds, release counter clears, state goes to PRESSED.
  - Otherwise col_idx <= col_idx+1 (3 wraps to 0).
- State PRESSED, on tick:
  - If row_s==4'b1111, the release counter increments; otherwise it clears.
  - When the counter reaches RELEASE_TICKS: key_pressed <= 0, col_idx <= col_idx+1 (wrapping), state goes to SCAN.
  - Additional keys while in PRESSED are ignored; key_code does not change and no key_valid is emitted.
- Rows are never evaluated between ticks.
- key_valid is never high for more than 1 cycle, and only on a SCAN->PRESSED transition.
- Latency from a key being physically closed to key_valid: up to 4 scan periods plus 1 tick (at most 5*SCAN_DIV + 3 clk).

Optional Feature:
- Macro: KEYPAD_GHOST_REJECT_EN.
- Defined: in SCAN, if more than one row_s bit is 0 on a tick, nothing is registered. col_idx advances as if no key were pressed, and no key_valid is emitted.
- Undefined: the lowest-index low row wins, as described above.

Test Plan:
- Reset/scan, SCAN_DIV=4, rows 4'hF:
  - After rst release, col_n=1110.
  - col_n becomes 1101, 1011, 0111 at 4-clk intervals, then wraps back to 1110 16 clk after release.
  - key_pressed=0 and key_valid=0 throughout.
- Single press, row_n[2]=0 while col_n=1101:
  - At the next tick: key_code=4'h9, key_valid high exactly 1 cycle, key_pressed=1.
  - col_n stays at 1101 while the key is held.
- Release with bounce, RELEASE_TICKS=3:
  - Rows high for 2 ticks, low for 1 tick, then high for 3 ticks.
  - key_pressed stays 1 through the bounce and drops on the 3rd consecutive high tick.
  - col_n then becomes 1011; no second key_valid.
- Two keys, rows 1 and 3 low on column 0:
  - Macro undefined: key_code=4'h4.
  - Macro defined: no key_valid; scanning continues to 1101.
- Press on column 3 (row 0): key_code=4'h3. After release, col_n wraps to 1110.
- rst asserted mid-press (key_pressed=1, key_code=4'h9):
  - One cycle later all outputs are at reset values.
  - Holding the key after reset re-registers it with a fresh key_valid once column 1 is scanned.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, registers the first key seen and holds it until release.
// Optional macro KEYPAD_GHOST_REJECT_EN: ignore scans where more than one row reads low on the active column.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 27000,
  parameter int unsigned RELEASE_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_pressed,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned REL_W = (RELEASE_TICKS > 0) ? $clog2(RELEASE_TICKS + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [REL_W-1:0] REL_DONE = REL_W'(RELEASE_TICKS);

  typedef enum logic {
    ST_SCAN,
    ST_PRESSED
  } state_e;

  state_e           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       row_s_q;
  logic [DIV_W-1:0] div_q;
  logic [REL_W-1:0] rel_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       col_n_q;
  logic             key_pressed_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;

  logic [3:0]       low_c;
  logic [1:0]       win_row_c;
  logic             accept_c;
  logic             tick_c;
  logic [1:0]       col_next_c;
  logic [REL_W-1:0] rel_inc_c;

  assign tick_c     = (div_q == DIV_LAST);
  assign low_c      = ~row_s_q;
  assign col_next_c = col_idx_q + 2'd1;
  assign rel_inc_c  = rel_q + REL_W'(1);

  // Lowest-index low row wins
  always_comb begin
    win_row_c = 2'd0;
    casez (low_c)
      4'b???1: win_row_c = 2'd0;
      4'b??10: win_row_c = 2'd1;
      4'b?100: win_row_c = 2'd2;
      4'b1000: win_row_c = 2'd3;
      default: win_row_c = 2'd0;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
`ifdef KEYPAD_GHOST_REJECT_EN
    // More than one low row on a column is treated as no key at all
    accept_c = (|low_c) && ((low_c & (low_c - 4'd1)) == 4'd0);
`else
    accept_c = |low_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SCAN;
      sync1_q       <= 4'b1111;
      row_s_q       <= 4'b1111;
      div_q         <= '0;
      rel_q         <= '0;
      col_idx_q     <= 2'd0;
      col_n_q       <= 4'b1110;
      key_pressed_q <= 1'b0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
    end else begin
      sync1_q     <= row_n;
      row_s_q     <= sync1_q;
      key_valid_q <= 1'b0;
      div_q       <= tick_c ? '0 : div_q + DIV_W'(1);

      if (tick_c) begin
        unique case (state_q)
          ST_SCAN: begin
            if (accept_c) begin
              key_code_q    <= {win_row_c, col_idx_q};
              key_pressed_q <= 1'b1;
              key_valid_q   <= 1'b1;
              rel_q         <= '0;
              state_q       <= ST_PRESSED;
            end else begin
              col_idx_q <= col_next_c;
              col_n_q   <= ~(4'b0001 << col_next_c);
            end
          end
          ST_PRESSED: begin
            // Release needs RELEASE_TICKS consecutive all-high ticks
            if (row_s_q == 4'b1111) begin
              if (rel_inc_c == REL_DONE) begin
                rel_q         <= '0;
                key_pressed_q <= 1'b0;
                col_idx_q     <= col_next_c;
                col_n_q       <= ~(4'b0001 << col_next_c);
                state_q       <= ST_SCAN;
              end else begin
                rel_q <= rel_inc_c;
              end
            end else begin
              rel_q <= '0;
            end
          end
          default: state_q <= ST_SCAN;
        endcase
      end
    end
  end

  assign col_n       = col_n_q;
  assign key_pressed = key_pressed_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboarded bench for keypad_scanner with a behavioural 4x4 key matrix; honours KEYPAD_GHOST_REJECT_EN.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV      = 4;
  localparam int unsigned RELEASE_TICKS = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_pressed;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] keys;

  int          checks;
  int          errors;
  logic [3:0]  exp_q[$];
  logic        prev_kv;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .RELEASE_TICKS(RELEASE_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_pressed(key_pressed),
    .key_code   (key_code),
    .key_valid  (key_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every key_valid pulse pops one expected code
  initial prev_kv = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_valid: got code %h expected no pulse at %0t", key_code, $time);
        end else begin
          check("key_valid_code", key_code, exp_q.pop_front());
        end
        if (prev_kv) begin
          checks++;
          errors++;
          $display("FAIL key_valid_width: got 2+ cycles expected 1 at %0t", $time);
        end
      end
      prev_kv = key_valid;
    end else begin
      prev_kv = 1'b0;
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    keys   = 16'h0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and idle column walk
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_pressed", {3'b0, key_pressed}, 4'h0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_key_valid", {3'b0, key_valid}, 4'h0);
    adv(3);  check("scan_col_hold", col_n, 4'b1110);
    adv(1);  check("scan_col1", col_n, 4'b1101);
    adv(4);  check("scan_col2", col_n, 4'b1011);
    adv(4);  check("scan_col3", col_n, 4'b0111);
    adv(4);  check("scan_wrap", col_n, 4'b1110);
    check("scan_no_press", {3'b0, key_pressed}, 4'h0);

    // Single press row 2 / column 1
    keys[9] = 1'b1;
    exp_q.push_back(4'h9);
    adv(8);
    check("press_kp", {3'b0, key_pressed}, 4'h1);
    check("press_code", key_code, 4'h9);
    check("press_kv", {3'b0, key_valid}, 4'h1);
    check("press_col", col_n, 4'b1101);
    adv(1);  check("press_kv_drop", {3'b0, key_valid}, 4'h0);
    adv(7);  check("hold_col", col_n, 4'b1101);
    check("hold_kp", {3'b0, key_pressed}, 4'h1);

    // Release with one bounce tick in the middle
    keys = 16'h0;
    adv(8);  check("bounce_kp_a", {3'b0, key_pressed}, 4'h1);
    keys[9] = 1'b1;
    adv(4);  check("bounce_kp_b", {3'b0, key_pressed}, 4'h1);
    keys = 16'h0;
    adv(8);  check("bounce_kp_c", {3'b0, key_pressed}, 4'h1);
    check("bounce_col", col_n, 4'b1101);
    adv(4);  check("release_kp", {3'b0, key_pressed}, 4'h0);
    check("release_col", col_n, 4'b1011);
    check("release_code_held", key_code, 4'h9);

    // Two keys on column 0, rows 1 and 3
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
`ifndef KEYPAD_GHOST_REJECT_EN
    exp_q.push_back(4'h4);
`endif
    adv(12);
`ifdef KEYPAD_GHOST_REJECT_EN
    check("ghost_kp", {3'b0, key_pressed}, 4'h0);
    check("ghost_code", key_code, 4'h9);
    check("ghost_col", col_n, 4'b1101);
`else
    check("multi_kp", {3'b0, key_pressed}, 4'h1);
    check("multi_code", key_code, 4'h4);
    check("multi_col", col_n, 4'b1110);
`endif
    keys = 16'h0;
    adv(12);
    rst = 1'b1;
    adv(1);
    rst = 1'b0;

    // Press on column 3 row 0, release wraps to column 0
    keys[3] = 1'b1;
    exp_q.push_back(4'h3);
    adv(16);
    check("col3_kp", {3'b0, key_pressed}, 4'h1);
    check("col3_code", key_code, 4'h3);
    check("col3_col", col_n, 4'b0111);
    keys = 16'h0;
    adv(8);  check("col3_hold_kp", {3'b0, key_pressed}, 4'h1);
    adv(4);  check("col3_release_kp", {3'b0, key_pressed}, 4'h0);
    check("col3_wrap_col", col_n, 4'b1110);

    // Reset mid-press, key held through reset
    keys[9] = 1'b1;
    exp_q.push_back(4'h9);
    adv(8);
    check("mid_kp", {3'b0, key_pressed}, 4'h1);
    check("mid_code", key_code, 4'h9);
    adv(4);
    rst = 1'b1;
    adv(1);
    check("mid_rst_col", col_n, 4'b1110);
    check("mid_rst_kp", {3'b0, key_pressed}, 4'h0);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_kv", {3'b0, key_valid}, 4'h0);
    rst = 1'b0;
    exp_q.push_back(4'h9);
    adv(7);  check("rereg_early_kp", {3'b0, key_pressed}, 4'h0);
    adv(1);
    check("rereg_kp", {3'b0, key_pressed}, 4'h1);
    check("rereg_code", key_code, 4'h9);
    check("rereg_kv", {3'b0, key_valid}, 4'h1);
    keys = 16'h0;
    adv(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_key_valid: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
